// File: rtl/ol_argmax_pkg.sv
// Shared definitions for the output-layer argmax block: FSM state encoding
// and a constant-evaluable ceiling-log2 helper for index widths.
package ol_argmax_pkg;

    typedef enum logic [1:0] {
        COLLECT = 2'd0,
        SCAN    = 2'd1,
        DONE    = 2'd2
    } state_e;

    // Ceiling log2; used to size class indices from the class count.
    function automatic int unsigned clog2(input int unsigned n);
        int unsigned r;
        r = 0;
        for (int unsigned v = 1; v < n; v = v << 1) begin
            r = r + 1;
        end
        return r;
    endfunction

endpackage

// File: rtl/ol_argmax.sv
// Output-layer argmax: collects one signed value per class (any order, any
// cycle), then scans the slots one per cycle and reports the winning class,
// its value and the OR of the captured overflow flags as a one-cycle strobe.
module ol_argmax
    import ol_argmax_pkg::*;
#(
    parameter int unsigned NUM_CLASSES = 10,
    parameter int unsigned WIDTH       = 8,
    localparam int unsigned IDX_W      = clog2(NUM_CLASSES)
) (
    input  logic                         CLK,
    input  logic                         RSTN,
    input  logic                         CLEAR,
    input  logic [NUM_CLASSES*WIDTH-1:0] VALUES_IN,
    input  logic [NUM_CLASSES-1:0]       VALIDS_IN,
    input  logic [NUM_CLASSES-1:0]       OVERFLOWS_IN,
    output logic [IDX_W-1:0]             CLASS_OUT,
    output logic [WIDTH-1:0]             VALUE_OUT,
    output logic                         VALID_OUT,
    output logic                         OVERFLOW_OUT,
    output logic                         BUSY
);

    localparam logic [IDX_W-1:0] LAST_PTR = IDX_W'(NUM_CLASSES - 1);

    logic [1:0] rst_sync_q;
    logic       rst_n;

    state_e                  state_q, state_d;
    logic [NUM_CLASSES-1:0]  captured_q, captured_d;
    logic                    sticky_q, sticky_d;
    logic signed [WIDTH-1:0] best_q, best_d;
    logic [IDX_W-1:0]        idx_q, idx_d;
    logic [IDX_W-1:0]        ptr_q, ptr_d;
    logic [IDX_W-1:0]        class_q, class_d;
    logic [WIDTH-1:0]        value_q, value_d;
    logic                    ovf_q, ovf_d;
    logic                    valid_q, valid_d;

    logic [NUM_CLASSES-1:0]  cap_en;
    logic signed [WIDTH-1:0] slot_q [NUM_CLASSES];
    logic signed [WIDTH-1:0] slot_d [NUM_CLASSES];

    // Reset synchroniser: assertion passes straight through, release is
    // delayed two clocks so every register leaves reset on the same edge.
    always_ff @(posedge CLK or negedge RSTN) begin
        if (!RSTN) begin
            rst_sync_q <= '0;
        end else begin
            rst_sync_q <= {rst_sync_q[0], 1'b1};
        end
    end

    assign rst_n = rst_sync_q[1];

    // Slot write enables: only while collecting, and CLEAR blocks capture.
    always_comb begin
        cap_en = '0;
        if (state_q == COLLECT && !CLEAR) begin
            cap_en = VALIDS_IN;
        end
    end

    // Per-class capture registers; the last pulse for a class wins.
    for (genvar i = 0; i < NUM_CLASSES; i++) begin : g_slot
        assign slot_d[i] = cap_en[i] ? VALUES_IN[i*WIDTH +: WIDTH] : slot_q[i];

        // Slot i register.
        always_ff @(posedge CLK or negedge rst_n) begin
            if (!rst_n) begin
                slot_q[i] <= '0;
            end else begin
                slot_q[i] <= slot_d[i];
            end
        end
    end

    // Next-state and datapath control for COLLECT / SCAN / DONE.
    always_comb begin
        state_d    = state_q;
        captured_d = captured_q;
        sticky_d   = sticky_q;
        best_d     = best_q;
        idx_d      = idx_q;
        ptr_d      = ptr_q;
        class_d    = class_q;
        value_d    = value_q;
        ovf_d      = ovf_q;
        valid_d    = 1'b0;

        if (CLEAR) begin
            state_d    = COLLECT;
            captured_d = '0;
            sticky_d   = 1'b0;
        end else begin
            unique case (state_q)
                COLLECT: begin
                    captured_d = captured_q | VALIDS_IN;
                    sticky_d   = sticky_q | (|(VALIDS_IN & OVERFLOWS_IN));
                    if (&captured_d) begin
                        // Seed from slot_d so a class-0 value arriving on this
                        // same edge is the one compared against.
                        state_d = SCAN;
                        best_d  = slot_d[0];
                        idx_d   = '0;
                        ptr_d   = IDX_W'(1);
                    end
                end
                SCAN: begin
                    if (slot_q[ptr_q] > best_q) begin
                        best_d = slot_q[ptr_q];
                        idx_d  = ptr_q;
                    end
                    ptr_d = ptr_q + 1'b1;
                    if (ptr_q == LAST_PTR) begin
                        state_d = DONE;
                    end
                end
                DONE: begin
                    class_d    = idx_q;
                    value_d    = best_q;
                    ovf_d      = sticky_q;
                    valid_d    = 1'b1;
                    captured_d = '0;
                    sticky_d   = 1'b0;
                    state_d    = COLLECT;
                end
                default: begin
                    state_d = COLLECT;
                end
            endcase
        end
    end

    // State, scan and result registers.
    always_ff @(posedge CLK or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= COLLECT;
            captured_q <= '0;
            sticky_q   <= 1'b0;
            best_q     <= '0;
            idx_q      <= '0;
            ptr_q      <= '0;
            class_q    <= '0;
            value_q    <= '0;
            ovf_q      <= 1'b0;
            valid_q    <= 1'b0;
        end else begin
            state_q    <= state_d;
            captured_q <= captured_d;
            sticky_q   <= sticky_d;
            best_q     <= best_d;
            idx_q      <= idx_d;
            ptr_q      <= ptr_d;
            class_q    <= class_d;
            value_q    <= value_d;
            ovf_q      <= ovf_d;
            valid_q    <= valid_d;
        end
    end

    assign CLASS_OUT    = class_q;
    assign VALUE_OUT    = value_q;
    assign VALID_OUT    = valid_q;
    assign OVERFLOW_OUT = ovf_q;
    assign BUSY         = (state_q == SCAN) || (state_q == DONE);

endmodule

// File: tb/tb_ol_argmax.sv
// Directed self-checking bench for ol_argmax with the default 10 x 8-bit
// configuration. Latency is counted in rising edges after the capture edge;
// the capture edge itself is edge 1, so the result strobe rises on the
// N-th following edge (N+1 edges in all).
module tb_ol_argmax;

    localparam int N     = 10;
    localparam int W     = 8;
    localparam int IDX_W = 4;

    logic             CLK;
    logic             RSTN;
    logic             CLEAR;
    logic [N*W-1:0]   VALUES_IN;
    logic [N-1:0]     VALIDS_IN;
    logic [N-1:0]     OVERFLOWS_IN;
    logic [IDX_W-1:0] CLASS_OUT;
    logic [W-1:0]     VALUE_OUT;
    logic             VALID_OUT;
    logic             OVERFLOW_OUT;
    logic             BUSY;

    int total;
    int bad;

    ol_argmax #(.NUM_CLASSES(N), .WIDTH(W)) dut (
        .CLK          (CLK),
        .RSTN         (RSTN),
        .CLEAR        (CLEAR),
        .VALUES_IN    (VALUES_IN),
        .VALIDS_IN    (VALIDS_IN),
        .OVERFLOWS_IN (OVERFLOWS_IN),
        .CLASS_OUT    (CLASS_OUT),
        .VALUE_OUT    (VALUE_OUT),
        .VALID_OUT    (VALID_OUT),
        .OVERFLOW_OUT (OVERFLOW_OUT),
        .BUSY         (BUSY)
    );

    initial CLK = 1'b0;
    always #5 CLK = ~CLK;

    // One-cycle pulse on a single class.
    task automatic drive_one(input int cls, input logic [W-1:0] v, input logic ovf);
        @(negedge CLK);
        VALUES_IN[cls*W +: W] = v;
        VALIDS_IN             = '0;
        VALIDS_IN[cls]        = 1'b1;
        OVERFLOWS_IN          = '0;
        OVERFLOWS_IN[cls]     = ovf;
        @(negedge CLK);
        VALIDS_IN    = '0;
        OVERFLOWS_IN = '0;
    endtask

    // One-cycle pulse on every class at once.
    task automatic drive_all(input logic [N*W-1:0] vals);
        @(negedge CLK);
        VALUES_IN = vals;
        VALIDS_IN = '1;
        @(negedge CLK);
        VALIDS_IN = '0;
    endtask

    // Bounded wait for the result strobe; lat = edges after the capture edge.
    task automatic wait_valid(output int lat, output logic got);
        lat = 0;
        got = 1'b0;
        for (int k = 1; k <= 40; k++) begin
            @(posedge CLK);
            #1;
            if (VALID_OUT === 1'b1) begin
                lat = k;
                got = 1'b1;
                break;
            end
        end
    endtask

    task automatic test_reset();
        RSTN = 1'b0; CLEAR = 1'b0; VALUES_IN = '0; VALIDS_IN = '0; OVERFLOWS_IN = '0;
        #12;
        total++; if (CLASS_OUT !== 4'd0) begin bad++; $display("FAIL rst_class: got %0d expected 0", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h00) begin bad++; $display("FAIL rst_value: got %0h expected 0", VALUE_OUT); end
        total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL rst_valid: got %0b expected 0", VALID_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL rst_ovf: got %0b expected 0", OVERFLOW_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL rst_busy: got %0b expected 0", BUSY); end
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (4) @(negedge CLK);
    endtask

    task automatic test_ascending();
        int lat; logic got;
        for (int i = 0; i < N; i++) begin
            drive_one(i, 8'(i + 1), 1'b0);
        end
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL asc_busy: got %0b expected 1", BUSY); end
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || lat != N) begin bad++; $display("FAIL asc_latency: got %0d (seen %0b) expected %0d", lat, got, N); end
        total++; if (CLASS_OUT !== 4'd9) begin bad++; $display("FAIL asc_class: got %0d expected 9", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h0A) begin bad++; $display("FAIL asc_value: got %0h expected 0a", VALUE_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL asc_ovf: got %0b expected 0", OVERFLOW_OUT); end
        @(posedge CLK); #1;
        total++; if (VALID_OUT !== 1'b0) begin bad++; $display("FAIL asc_pulse_width: got %0b expected 0", VALID_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL asc_busy_after: got %0b expected 0", BUSY); end
    endtask

    task automatic test_signed();
        int lat; logic got;
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'hF0;
        v[3*W +: W] = 8'hFF;
        drive_all(v);
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || CLASS_OUT !== 4'd3) begin bad++; $display("FAIL neg_class: got %0d expected 3", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'hFF) begin bad++; $display("FAIL neg_value: got %0h expected ff", VALUE_OUT); end
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'hF0;
        v[2*W +: W] = 8'h7F;
        v[7*W +: W] = 8'h7F;
        drive_all(v);
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || CLASS_OUT !== 4'd2) begin bad++; $display("FAIL tie_class: got %0d expected 2", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h7F) begin bad++; $display("FAIL tie_value: got %0h expected 7f", VALUE_OUT); end
    endtask

    task automatic test_overwrite_ovf();
        int lat; logic got;
        drive_one(5, 8'h7F, 1'b0);
        drive_one(5, 8'h01, 1'b0);
        for (int i = 0; i < N; i++) begin
            if (i != 5) drive_one(i, 8'h10, (i == 4));
        end
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || CLASS_OUT !== 4'd0) begin bad++; $display("FAIL ovw_class: got %0d expected 0", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h10) begin bad++; $display("FAIL ovw_value: got %0h expected 10", VALUE_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b1) begin bad++; $display("FAIL ovw_ovf: got %0b expected 1", OVERFLOW_OUT); end
    endtask

    task automatic test_simultaneous();
        int lat; logic got;
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'(8'h50 - i);
        drive_all(v);
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || lat != N) begin bad++; $display("FAIL sim_latency: got %0d (seen %0b) expected %0d", lat, got, N); end
        total++; if (CLASS_OUT !== 4'd0) begin bad++; $display("FAIL sim_class: got %0d expected 0", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h50) begin bad++; $display("FAIL sim_value: got %0h expected 50", VALUE_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL sim_ovf_cleared: got %0b expected 0", OVERFLOW_OUT); end
    endtask

    task automatic test_clear_abort();
        int lat; logic got;
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'h05;
        v[6*W +: W] = 8'h60;
        drive_all(v);
        repeat (2) @(negedge CLK);
        total++; if (BUSY !== 1'b1) begin bad++; $display("FAIL clr_busy_before: got %0b expected 1", BUSY); end
        CLEAR = 1'b1;
        @(negedge CLK);
        CLEAR = 1'b0;
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL clr_busy_drop: got %0b expected 0", BUSY); end
        wait_valid(lat, got);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL clr_no_valid: got %0b expected 0", got); end
        total++; if (CLASS_OUT !== 4'd0) begin bad++; $display("FAIL clr_hold_class: got %0d expected 0", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h50) begin bad++; $display("FAIL clr_hold_value: got %0h expected 50", VALUE_OUT); end
        drive_all(v);
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || lat != N) begin bad++; $display("FAIL clr_rerun_latency: got %0d (seen %0b) expected %0d", lat, got, N); end
        total++; if (CLASS_OUT !== 4'd6) begin bad++; $display("FAIL clr_rerun_class: got %0d expected 6", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h60) begin bad++; $display("FAIL clr_rerun_value: got %0h expected 60", VALUE_OUT); end
    endtask

    task automatic test_ignore_in_scan();
        int lat; logic got;
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'h00;
        v[1*W +: W] = 8'h40;
        drive_all(v);
        drive_one(8, 8'h7F, 1'b1);
        wait_valid(lat, got);
        total++; if (got !== 1'b1 || CLASS_OUT !== 4'd1) begin bad++; $display("FAIL ign_class: got %0d expected 1", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h40) begin bad++; $display("FAIL ign_value: got %0h expected 40", VALUE_OUT); end
        total++; if (OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL ign_ovf: got %0b expected 0", OVERFLOW_OUT); end
    endtask

    task automatic test_reset_mid_scan();
        int lat; logic got;
        logic [N*W-1:0] v;
        for (int i = 0; i < N; i++) v[i*W +: W] = 8'h11;
        drive_all(v);
        @(negedge CLK);
        #2;
        RSTN = 1'b0;
        #1;
        total++; if (CLASS_OUT !== 4'd0) begin bad++; $display("FAIL mrst_class: got %0d expected 0", CLASS_OUT); end
        total++; if (VALUE_OUT !== 8'h00) begin bad++; $display("FAIL mrst_value: got %0h expected 0", VALUE_OUT); end
        total++; if (BUSY !== 1'b0) begin bad++; $display("FAIL mrst_busy: got %0b expected 0", BUSY); end
        total++; if (VALID_OUT !== 1'b0 || OVERFLOW_OUT !== 1'b0) begin bad++; $display("FAIL mrst_flags: got %0b%0b expected 00", VALID_OUT, OVERFLOW_OUT); end
        @(negedge CLK);
        RSTN = 1'b1;
        repeat (3) @(negedge CLK);
        wait_valid(lat, got);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL mrst_no_valid: got %0b expected 0", got); end
        drive_one(9, 8'h22, 1'b0);
        wait_valid(lat, got);
        total++; if (got !== 1'b0) begin bad++; $display("FAIL mrst_captured_cleared: got %0b expected 0", got); end
    endtask

    initial begin
        total = 0;
        bad   = 0;
        test_reset();
        test_ascending();
        test_signed();
        test_overwrite_ovf();
        test_simultaneous();
        test_clear_abort();
        test_ignore_in_scan();
        test_reset_mid_scan();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
